// File: rtl/uart_loopback_core.sv
// 8N1 UART transmitter and receiver sharing one clock, with the receiver
// listening to the transmitter's own serial line (loopback).
module uart_loopback_core #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       res_n,
    output logic [7:0] out_RX,
    output logic       rxDone,
    output logic       tx,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       txDone,
    output logic       txBusy
);
    localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
    localparam int RX_DIV = CLOCK_RATE / (16 * BAUD_RATE);
    localparam int TXCW   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int RXCW   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam logic [TXCW-1:0] TX_LAST = TXCW'(TX_DIV - 1);
    localparam logic [RXCW-1:0] RX_LAST = RXCW'(RX_DIV - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    logic [TXCW-1:0] txCnt;
    logic [RXCW-1:0] rxCnt;
    logic            txTick, rxTick;

    // Baud enables: single-cycle strobes, not derived clocks
    assign txTick = (txCnt == TX_LAST);
    assign rxTick = (rxCnt == RX_LAST);

    always_ff @(posedge clk) begin
        if (res_n) begin
            txCnt <= '0;
            rxCnt <= '0;
        end else begin
            txCnt <= txTick ? '0 : txCnt + 1'b1;
            rxCnt <= rxTick ? '0 : rxCnt + 1'b1;
        end
    end

    txState_t   txState, txStateNext;
    logic [7:0] txShift, txShiftNext;
    logic [2:0] txIdx, txIdxNext;
    logic       txNext, txBusyNext, txDoneNext;

    always_ff @(posedge clk) begin
        if (res_n) begin
            txState <= TX_IDLE;
            txShift <= '0;
            txIdx   <= '0;
            tx      <= 1'b1;
            txBusy  <= 1'b0;
            txDone  <= 1'b0;
        end else begin
            txState <= txStateNext;
            txShift <= txShiftNext;
            txIdx   <= txIdxNext;
            tx      <= txNext;
            txBusy  <= txBusyNext;
            txDone  <= txDoneNext;
        end
    end

    always_comb begin
        txStateNext = txState;
        txShiftNext = txShift;
        txIdxNext   = txIdx;
        txNext      = tx;
        txBusyNext  = txBusy;
        txDoneNext  = 1'b0;
        if (txTick) begin
            case (txState)
                TX_IDLE: if (txEn && txStart) begin
                    txShiftNext = in;
                    txNext      = 1'b0;
                    txBusyNext  = 1'b1;
                    txStateNext = TX_START;
                end
                TX_START: begin
                    txNext      = txShift[0];
                    txIdxNext   = '0;
                    txStateNext = TX_DATA;
                end
                TX_DATA: if (txIdx != 3'd7) begin
                    txShiftNext = {1'b0, txShift[7:1]};
                    txNext      = txShift[1];
                    txIdxNext   = txIdx + 1'b1;
                end else begin
                    txNext      = 1'b1;
                    txStateNext = TX_STOP;
                end
                TX_STOP: begin
                    txDoneNext = 1'b1;
                    // Back-to-back: the next start bit begins on this same tick
                    if (txEn && txStart) begin
                        txShiftNext = in;
                        txNext      = 1'b0;
                        txStateNext = TX_START;
                    end else begin
                        txBusyNext  = 1'b0;
                        txStateNext = TX_IDLE;
                    end
                end
                default: txStateNext = TX_IDLE;
            endcase
        end
    end

    rxState_t   rxState, rxStateNext;
    logic [1:0] rxSync;
    logic       rxLine;
    logic [3:0] rxTicks, rxTicksNext;
    logic [2:0] rxIdx, rxIdxNext;
    logic [7:0] rxShift, rxShiftNext, outRxNext;
    logic       rxDoneNext;

    assign rxLine = rxSync[1];

    always_ff @(posedge clk) begin
        if (res_n) begin
            rxSync  <= 2'b11;
            rxState <= RX_IDLE;
            rxTicks <= '0;
            rxIdx   <= '0;
            rxShift <= '0;
            out_RX  <= 8'h00;
            rxDone  <= 1'b0;
        end else begin
            rxSync  <= {rxSync[0], tx};
            rxState <= rxStateNext;
            rxTicks <= rxTicksNext;
            rxIdx   <= rxIdxNext;
            rxShift <= rxShiftNext;
            out_RX  <= outRxNext;
            rxDone  <= rxDoneNext;
        end
    end

    always_comb begin
        rxStateNext = rxState;
        rxTicksNext = rxTicks;
        rxIdxNext   = rxIdx;
        rxShiftNext = rxShift;
        outRxNext   = out_RX;
        rxDoneNext  = 1'b0;
        if (rxTick) begin
            case (rxState)
                RX_IDLE: if (!rxLine) begin
                    rxTicksNext = '0;
                    rxStateNext = RX_START;
                end
                // Re-check at mid start bit to reject glitches
                RX_START: if (rxTicks == 4'd7) begin
                    rxTicksNext = '0;
                    rxIdxNext   = '0;
                    rxStateNext = rxLine ? RX_IDLE : RX_DATA;
                end else begin
                    rxTicksNext = rxTicks + 1'b1;
                end
                RX_DATA: if (rxTicks == 4'd15) begin
                    rxTicksNext = '0;
                    rxShiftNext = {rxLine, rxShift[7:1]};
                    rxIdxNext   = rxIdx + 1'b1;
                    if (rxIdx == 3'd7) rxStateNext = RX_STOP;
                end else begin
                    rxTicksNext = rxTicks + 1'b1;
                end
                RX_STOP: if (rxTicks == 4'd15) begin
                    rxTicksNext = '0;
                    rxStateNext = RX_IDLE;
                    if (rxLine) begin
                        outRxNext  = rxShift;
                        rxDoneNext = 1'b1;
                    end
                end else begin
                    rxTicksNext = rxTicks + 1'b1;
                end
                default: rxStateNext = RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loopback_core.sv
// Bench for uart_loopback_core: table-driven and random frames checked
// against a frame/scoreboard model of the 8N1 link.
module tb_uart_loopback_core;
    localparam int TX_DIV = 16;

    logic       clk = 1'b0;
    logic       res_n;
    logic [7:0] out_RX;
    logic       rxDone;
    logic       tx;
    logic       txEn;
    logic       txStart;
    logic [7:0] in;
    logic       txDone;
    logic       txBusy;

    uart_loopback_core #(.CLOCK_RATE(1600), .BAUD_RATE(100)) dut (
        .clk(clk), .res_n(res_n), .out_RX(out_RX), .rxDone(rxDone), .tx(tx),
        .txEn(txEn), .txStart(txStart), .in(in), .txDone(txDone), .txBusy(txBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int cyc = 0, txDoneCnt = 0, rxDoneCnt = 0, busyCyc = 0, txLowCyc = 0;
    int txDoneCyc = 0, rxDoneCyc = 0;
    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];
    int sbIdx = 0;

    always @(negedge clk) begin
        cyc++;
        if (txDone) begin txDoneCnt++; txDoneCyc = cyc; end
        if (rxDone) begin rxDoneCnt++; rxDoneCyc = cyc; rxQ.push_back(out_RX); end
        if (txBusy) busyCyc++;
        if (!tx) txLowCyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model of one 8N1 frame on the wire, LSB first
    function automatic logic [9:0] frameOf(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic scoreboard(input string nm);
        chk({nm, "_rxcount"}, rxQ.size(), expQ.size());
        while (sbIdx < rxQ.size() && sbIdx < expQ.size()) begin
            chk($sformatf("%s_byte%0d", nm, sbIdx), rxQ[sbIdx], expQ[sbIdx]);
            sbIdx++;
        end
    endtask

    task automatic waitBusy(output bit ok);
        int n = 0;
        while (!txBusy && n < 40) begin @(negedge clk); n++; end
        ok = txBusy;
    endtask

    // Called half a clock into the start bit; samples each bit mid-period
    task automatic checkFrame(input logic [9:0] exp, input string nm);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_bit%0d", nm, i), tx, exp[i]);
            if (i < 9) repeat (16) @(negedge clk);
        end
        chk({nm, "_busy_in_stop"}, txBusy, 1'b1);
    endtask

    task automatic sendSingle(input logic [7:0] d, input logic [9:0] exp, input string nm,
                              input bit changeIn, input bit dropEn);
        bit ok;
        int n, t0, r0, b0, dd;
        t0 = txDoneCnt; r0 = rxDoneCnt; b0 = busyCyc;
        in = d; txStart = 1'b1;
        waitBusy(ok);
        chk({nm, "_busy_rise"}, ok, 1'b1);
        if (!ok) begin txStart = 1'b0; return; end
        txStart = 1'b0;
        if (changeIn) in = ~d;
        if (dropEn) begin txEn = 1'b0; txStart = 1'b1; end
        expQ.push_back(d);
        checkFrame(exp, nm);
        n = 0;
        while (txBusy && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_busy_fall"}, txBusy, 1'b0);
        repeat (40) @(negedge clk);
        chk({nm, "_txdone_cnt"}, txDoneCnt - t0, 1);
        chk({nm, "_rxdone_cnt"}, rxDoneCnt - r0, 1);
        chk({nm, "_busy_len"}, busyCyc - b0, 10 * TX_DIV);
        dd = rxDoneCyc - txDoneCyc;
        chk({nm, "_rx_near_tx"}, (dd >= -TX_DIV && dd <= TX_DIV), 1'b1);
        chk({nm, "_tx_idle"}, tx, 1'b1);
        scoreboard(nm);
        txStart = 1'b0; txEn = 1'b1;
    endtask

    initial begin
        vec_t vecs[5];
        bit ok;
        int t0, r0, b0, l0;
        logic [7:0] d;

        vecs[0] = '{8'h41, 10'h282};
        vecs[1] = '{8'h4C, 10'h298};
        vecs[2] = '{8'h51, 10'h2A2};
        vecs[3] = '{8'h6C, 10'h2D8};
        vecs[4] = '{8'h46, 10'h28C};

        res_n = 1'b1; txEn = 1'b0; txStart = 1'b0; in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", txBusy, 1'b0);
        chk("rst_txdone", txDone, 1'b0);
        chk("rst_rxdone", rxDone, 1'b0);
        chk("rst_outrx", out_RX, 8'h00);
        res_n = 1'b0;

        // Enabled but no start request: line stays idle
        txEn = 1'b1;
        b0 = busyCyc; l0 = txLowCyc;
        repeat (60) @(negedge clk);
        chk("nostart_busy", busyCyc - b0, 0);
        chk("nostart_txlow", txLowCyc - l0, 0);

        sendSingle(vecs[0].data, vecs[0].frame, "single41", 0, 0);
        chk("single41_outrx", out_RX, 8'h41);

        // Back-to-back frames with txStart held high
        t0 = txDoneCnt; r0 = rxDoneCnt; b0 = busyCyc;
        in = vecs[0].data; txStart = 1'b1;
        waitBusy(ok);
        chk("b2b_busy_rise", ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(vecs[i].data);
            if (i < 4) in = vecs[i + 1].data;
            else txStart = 1'b0;
            checkFrame(vecs[i].frame, $sformatf("b2b%0d", i));
            repeat (8) @(negedge clk);
        end
        chk("b2b_busy_end", txBusy, 1'b0);
        repeat (40) @(negedge clk);
        chk("b2b_txdone_cnt", txDoneCnt - t0, 5);
        chk("b2b_rxdone_cnt", rxDoneCnt - r0, 5);
        chk("b2b_busy_len", busyCyc - b0, 50 * TX_DIV);
        scoreboard("b2b");
        chk("b2b_outrx", out_RX, 8'h46);

        // Disabled transmitter ignores start
        txEn = 1'b0; txStart = 1'b1;
        t0 = txDoneCnt; r0 = rxDoneCnt; b0 = busyCyc; l0 = txLowCyc;
        repeat (100) @(negedge clk);
        chk("dis_busy", busyCyc - b0, 0);
        chk("dis_txlow", txLowCyc - l0, 0);
        chk("dis_txdone", txDoneCnt - t0, 0);
        chk("dis_rxdone", rxDoneCnt - r0, 0);
        txStart = 1'b0; txEn = 1'b1;

        sendSingle(8'h5A, 10'h2B4, "endrop", 0, 1);
        sendSingle(8'h33, 10'h266, "inchg", 1, 0);
        chk("inchg_outrx", out_RX, 8'h33);

        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            sendSingle(d, frameOf(d), $sformatf("rand%0d", k), bit'($urandom_range(0, 1)), 0);
        end

        // Reset during the data bits aborts the frame
        t0 = txDoneCnt; r0 = rxDoneCnt;
        in = 8'hA5; txStart = 1'b1;
        waitBusy(ok);
        chk("abort_busy_rise", ok, 1'b1);
        txStart = 1'b0;
        repeat (50) @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", txBusy, 1'b0);
        res_n = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_txdone", txDoneCnt - t0, 0);
        chk("abort_rxdone", rxDoneCnt - r0, 0);
        chk("abort_outrx", out_RX, 8'h00);
        scoreboard("abort");

        sendSingle(vecs[4].data, vecs[4].frame, "post46", 0, 0);
        chk("post46_outrx", out_RX, 8'h46);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
